// File: rtl/fabscalar_pkg.sv
// Shared FabScalar widths and FU result packet layout (mask at the top, packet valid bit at bit 0).
package fabscalar_pkg;

    localparam int CHECKPOINTS         = 4;
    localparam int CHECKPOINTS_LOG     = 2;
    localparam int EXECUTION_FLAGS     = 4;
    localparam int SIZE_PHYSICAL_LOG   = 7;
    localparam int SIZE_ACTIVELIST_LOG = 7;
    localparam int SIZE_DATA           = 32;
    localparam int SIZE_ISSUEQ_LOG     = 5;
    localparam int SIZE_LSQ_LOG        = 5;
    localparam int SIZE_CTI_LOG        = 4;
    localparam int SIZE_PC             = 32;

    localparam int FU_OUT_PKT_W = CHECKPOINTS + EXECUTION_FLAGS + SIZE_PHYSICAL_LOG
                                + SIZE_ACTIVELIST_LOG + SIZE_DATA + SIZE_ISSUEQ_LOG
                                + SIZE_LSQ_LOG + CHECKPOINTS_LOG + SIZE_CTI_LOG + SIZE_PC + 1;

    // Field low-bit offsets, packed MSB to LSB in the order of the width sum above.
    localparam int PKT_MASK_LO   = FU_OUT_PKT_W - CHECKPOINTS;
    localparam int PKT_FLAGS_LO  = PKT_MASK_LO - EXECUTION_FLAGS;
    localparam int PKT_DEST_LO   = PKT_FLAGS_LO - SIZE_PHYSICAL_LOG;
    localparam int PKT_AL_LO     = PKT_DEST_LO - SIZE_ACTIVELIST_LOG;
    localparam int PKT_RESULT_LO = PKT_AL_LO - SIZE_DATA;
    localparam int PKT_IQ_LO     = PKT_RESULT_LO - SIZE_ISSUEQ_LOG;
    localparam int PKT_LSQ_LO    = PKT_IQ_LO - SIZE_LSQ_LOG;
    localparam int PKT_SMT_LO    = PKT_LSQ_LO - CHECKPOINTS_LOG;
    localparam int PKT_CTI_LO    = PKT_SMT_LO - SIZE_CTI_LOG;
    localparam int PKT_PC_LO     = PKT_CTI_LO - SIZE_PC;

    typedef logic [FU_OUT_PKT_W-1:0] fu_pkt_t;

    function automatic fu_pkt_t clear_mask_bit(input fu_pkt_t p, input logic en,
                                               input logic [CHECKPOINTS_LOG-1:0] idx);
        fu_pkt_t                r;
        logic [CHECKPOINTS-1:0] m;
        r = p;
        m = p[PKT_MASK_LO +: CHECKPOINTS];
        if (en) m[idx] = 1'b0;
        r[PKT_MASK_LO +: CHECKPOINTS] = m;
        return r;
    endfunction

endpackage

// File: rtl/fu1_wb_queue.sv
// FU1 writeback queue: circular result buffer with branch-mask clear / mispredict flush; optional head bypass (FU1_WB_BYPASS_EN).
// Latency: one cycle from accepted push to outValid_o; flushed holes drain one per cycle.
// Backpressure: inReady_o = (count < DEPTH) from registered state; producer holds inputs while not ready.
module fu1_wb_queue
    import fabscalar_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [FU_OUT_PKT_W-1:0]      inPacket_i,
    input  logic                         inValid_i,
    output logic                         inReady_o,
    input  logic                         ctrlVerified_i,
    input  logic                         ctrlMispredict_i,
    input  logic [CHECKPOINTS_LOG-1:0]   ctrlSMTid_i,
    input  logic                         wbReady_i,
    output logic [FU_OUT_PKT_W-1:0]      outPacket_o,
    output logic                         outValid_o,
    output logic                         bypassValid_o,
    output logic [SIZE_PHYSICAL_LOG-1:0] bypassTag_o,
    output logic [SIZE_DATA-1:0]         bypassData_o
);

    localparam int               PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0]       head;
    logic [PTR_W-1:0]       tail;
    logic [PTR_W:0]         count;
    fu_pkt_t                pkt_q [DEPTH];
    logic [DEPTH-1:0]       vld_q;

    logic                   verify_ok;
    logic                   misp;
    fu_pkt_t                head_pkt;
    logic [CHECKPOINTS-1:0] head_mask;
    logic [CHECKPOINTS-1:0] in_mask;
    logic                   head_live;
    logic                   head_kill;
    logic                   in_kill;
    logic                   push;
    logic                   pop;
    fu_pkt_t                in_wr;

    assign verify_ok = ctrlVerified_i && !ctrlMispredict_i;
    assign misp      = ctrlVerified_i && ctrlMispredict_i;

    assign head_pkt  = pkt_q[head];
    assign head_mask = head_pkt[PKT_MASK_LO +: CHECKPOINTS];
    assign in_mask   = inPacket_i[PKT_MASK_LO +: CHECKPOINTS];

    assign head_live = (count != '0) && vld_q[head];
    assign head_kill = misp && head_mask[ctrlSMTid_i];

    assign inReady_o   = (count < DEPTH_C);
    assign outValid_o  = head_live && !head_kill;
    // Gated so the packet bus reads zero whenever the head is empty or a hole (including under reset).
    assign outPacket_o = head_live ? clear_mask_bit(head_pkt, verify_ok, ctrlSMTid_i) : '0;

    assign in_kill = misp && in_mask[ctrlSMTid_i];
    assign push    = inValid_i && inReady_o && !in_kill;
    assign pop     = (outValid_o && wbReady_i) || ((count != '0) && !vld_q[head]);
    assign in_wr   = clear_mask_bit(inPacket_i, verify_ok, ctrlSMTid_i);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        fu_pkt_t                pkt_r;
        logic                   vld_r;
        logic [CHECKPOINTS-1:0] mask_r;
        logic                   wr_here;
        logic                   pop_here;

        assign mask_r   = pkt_r[PKT_MASK_LO +: CHECKPOINTS];
        assign wr_here  = push && (tail == PTR_W'(i));
        assign pop_here = pop && (head == PTR_W'(i));

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                vld_r <= 1'b0;
            end else if (wr_here) begin
                vld_r <= 1'b1;
            end else if (pop_here || (misp && mask_r[ctrlSMTid_i])) begin
                vld_r <= 1'b0;
            end
        end

        // Payload needs no reset: it is only observed through a live valid bit.
        always_ff @(posedge clk) begin
            if (wr_here) begin
                pkt_r <= in_wr;
            end else if (verify_ok) begin
                pkt_r <= clear_mask_bit(pkt_r, 1'b1, ctrlSMTid_i);
            end
        end

        assign pkt_q[i]  = pkt_r;
        assign vld_q[i]  = vld_r;
    end

`ifdef FU1_WB_BYPASS_EN
    assign bypassValid_o = outValid_o;
    assign bypassTag_o   = head_live ? head_pkt[PKT_DEST_LO +: SIZE_PHYSICAL_LOG] : '0;
    assign bypassData_o  = head_live ? head_pkt[PKT_RESULT_LO +: SIZE_DATA] : '0;
`else
    assign bypassValid_o = 1'b0;
    assign bypassTag_o   = '0;
    assign bypassData_o  = '0;
`endif

endmodule
